// File: rtl/rs485_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rs485_link_ctrl
// Purpose  : Half-duplex RS485 link controller. Arbitrates two single-byte
//            requesters onto one uart_send instance, waits for the bus to be
//            idle (carrier sense on rxd), and frames each byte with a driver
//            enable lead/tail window. A transmit that stalls is aborted with a
//            one-cycle tx_err pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk      in   1  system clock, rising edge
//   sys_rst_n    in   1  asynchronous active-low reset
//   req_a/data_a in 1/8  requester A send pulse and byte
//   req_b/data_b in 1/8  requester B send pulse and byte
//   ack_a/ack_b  out  1  one-cycle pulse when that byte goes to uart_send
//   uart_en      out  1  one-cycle send strobe to uart_send
//   uart_din     out  8  byte for uart_send, held until back in IDLE
//   tx_busy      in   1  uart_send frame-in-progress flag
//   rxd          in   1  raw RS485 receive line (idle = 1)
//   rs485_tx_en  out  1  transceiver driver enable (registered)
//   tx_err       out  1  one-cycle pulse on transmit timeout
// ============================================================================
module rs485_link_ctrl #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int LEAD_BITS = 1,
  parameter int TAIL_BITS = 1,
  parameter int IDLE_BITS = 12
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       uart_en,
  output logic [7:0] uart_din,
  input  logic       tx_busy,
  input  logic       rxd,
  output logic       rs485_tx_en,
  output logic       tx_err
);

  localparam int BIT_CYC   = CLK_FREQ / UART_BPS;
  localparam int LEAD_CYC  = LEAD_BITS * BIT_CYC;
  localparam int TAIL_CYC  = TAIL_BITS * BIT_CYC;
  localparam int IDLE_CYC  = IDLE_BITS * BIT_CYC;
  localparam int BUSY_TMO  = 12 * BIT_CYC;
  localparam int START_TMO = 4;

  // Shared counter must cover the longest timed interval of any state.
  localparam int CNT_MAX = (BUSY_TMO > LEAD_CYC) ?
                           ((BUSY_TMO > TAIL_CYC) ? BUSY_TMO : TAIL_CYC) :
                           ((LEAD_CYC > TAIL_CYC) ? LEAD_CYC : TAIL_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDLE_W  = $clog2(IDLE_CYC + 1);

  localparam logic [CNT_W-1:0]  LEAD_LAST  = CNT_W'(LEAD_CYC - 1);
  localparam logic [CNT_W-1:0]  TAIL_LAST  = CNT_W'(TAIL_CYC - 1);
  localparam logic [CNT_W-1:0]  BUSY_LAST  = CNT_W'(BUSY_TMO - 1);
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_TMO);
  localparam logic [IDLE_W-1:0] IDLE_FULL  = IDLE_W'(IDLE_CYC);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_TAIL  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q,  idle_cnt_d;
  logic                rxd_meta_q,  rxd_sync_q;
  logic                pend_a_q,    pend_a_d;
  logic                pend_b_q,    pend_b_d;
  logic [7:0]          data_a_q,    data_a_d;
  logic [7:0]          data_b_q,    data_b_d;
  logic                last_b_q,    last_b_d;
  logic                busy_seen_q, busy_seen_d;
  logic                tx_en_q,     tx_en_d;
  logic                uart_en_q,   uart_en_d;
  logic [7:0]          uart_din_q,  uart_din_d;
  logic                ack_a_q,     ack_a_d;
  logic                ack_b_q,     ack_b_d;
  logic                tx_err_q,    tx_err_d;

  logic w_grant;
  logic w_gnt_b;

  // Round-robin: B wins only when A is not pending or A was served last.
  assign w_gnt_b = pend_b_q & (~pend_a_q | ~last_b_q);
  assign w_grant = (state_q == ST_IDLE) & (pend_a_q | pend_b_q) &
                   (idle_cnt_q == IDLE_FULL);

  // Pending registers: a new request takes priority over the grant-clear so
  // a request landing on the grant cycle becomes the next pending entry.
  always_comb begin
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (w_grant && !w_gnt_b) pend_a_d = 1'b0;
    if (w_grant &&  w_gnt_b) pend_b_d = 1'b0;
    if (req_a) begin
      pend_a_d = 1'b1;
      data_a_d = data_a;
    end
    if (req_b) begin
      pend_b_d = 1'b1;
      data_b_d = data_b;
    end
  end

  // Carrier sense: consecutive idle cycles on the synchronised line. GUARD
  // restarts the count so every frame is followed by a full idle gap.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q == ST_GUARD || !rxd_sync_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_FULL) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_en_d     = tx_en_q;
    uart_din_d  = uart_din_q;
    last_b_d    = last_b_q;
    uart_en_d   = 1'b0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    tx_err_d    = 1'b0;
    busy_seen_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_grant) begin
          state_d    = ST_LEAD;
          tx_en_d    = 1'b1;
          uart_din_d = w_gnt_b ? data_b_q : data_a_q;
          last_b_d   = w_gnt_b;
        end
      end
      ST_LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          state_d   = ST_SEND;
          uart_en_d = 1'b1;
          ack_a_d   = ~last_b_q;
          ack_b_d   = last_b_q;
        end
      end
      ST_SEND: begin
        // cnt_q counts cycles since the uart_en strobe (0 = strobe cycle).
        busy_seen_d = busy_seen_q | tx_busy;
        if (busy_seen_q && !tx_busy) begin
          state_d = ST_TAIL;
        end else if ((!busy_seen_q && !tx_busy && cnt_q == START_LAST) ||
                     (cnt_q == BUSY_LAST)) begin
          state_d  = ST_GUARD;
          tx_en_d  = 1'b0;
          tx_err_d = 1'b1;
        end
      end
      ST_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          state_d = ST_GUARD;
          tx_en_d = 1'b0;
        end
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
        tx_en_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        tx_en_d = 1'b0;
      end
    endcase

    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_GUARD) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idle_cnt_q  <= '0;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      pend_a_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      data_a_q    <= 8'h00;
      data_b_q    <= 8'h00;
      last_b_q    <= 1'b1;
      busy_seen_q <= 1'b0;
      tx_en_q     <= 1'b0;
      uart_en_q   <= 1'b0;
      uart_din_q  <= 8'h00;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      last_b_q    <= last_b_d;
      busy_seen_q <= busy_seen_d;
      tx_en_q     <= tx_en_d;
      uart_en_q   <= uart_en_d;
      uart_din_q  <= uart_din_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign rs485_tx_en = tx_en_q;
  assign uart_en     = uart_en_q;
  assign uart_din    = uart_din_q;
  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign tx_err      = tx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rs485_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs485_link_ctrl
// Purpose  : Directed/randomised bench for rs485_link_ctrl with a behavioural
//            model of the pending registers and round-robin arbitration, plus
//            a simple uart_send stand-in driving tx_busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs485_link_ctrl;

  localparam int BIT_CYC  = 50000000 / 115200;
  localparam int LEAD_CYC = BIT_CYC;
  localparam int TAIL_CYC = BIT_CYC;
  localparam int IDLE_CYC = 12 * BIT_CYC;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req_a     = 1'b0;
  logic       req_b     = 1'b0;
  logic [7:0] data_a    = 8'h00;
  logic [7:0] data_b    = 8'h00;
  logic       tx_busy   = 1'b0;
  logic       rxd       = 1'b1;
  logic       ack_a, ack_b, uart_en, rs485_tx_en, tx_err;
  logic [7:0] uart_din;

  rs485_link_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_a       (req_a),
    .data_a      (data_a),
    .req_b       (req_b),
    .data_b      (data_b),
    .ack_a       (ack_a),
    .ack_b       (ack_b),
    .uart_en     (uart_en),
    .uart_din    (uart_din),
    .tx_busy     (tx_busy),
    .rxd         (rxd),
    .rs485_tx_en (rs485_tx_en),
    .tx_err      (tx_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse counters observed on the DUT outputs.
  int cnt_ack_a = 0, cnt_ack_b = 0, cnt_uen = 0, cnt_err = 0;
  always @(negedge sys_clk) begin
    if (ack_a)   cnt_ack_a <= cnt_ack_a + 1;
    if (ack_b)   cnt_ack_b <= cnt_ack_b + 1;
    if (uart_en) cnt_uen   <= cnt_uen + 1;
    if (tx_err)  cnt_err   <= cnt_err + 1;
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  // Reference model: one pending slot per requester, latest byte wins,
  // ties go to whoever was not served last.
  bit         m_pend_a = 0, m_pend_b = 0, m_last_b = 1;
  logic [7:0] m_data_a = 0, m_data_b = 0;
  int         m_ack_a = 0, m_ack_b = 0, m_err = 0;
  int         t_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_total++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic bit m_pick();
    if (m_pend_a && m_pend_b) return !m_last_b;
    return m_pend_b;
  endfunction

  function automatic void m_grant(input bit b);
    m_last_b = b;
    if (b) begin m_pend_b = 0; m_ack_b++; end
    else   begin m_pend_a = 0; m_ack_a++; end
  endfunction

  function automatic void m_reset();
    m_pend_a = 0; m_pend_b = 0; m_last_b = 1;
  endfunction

  task automatic request(input bit do_a, input logic [7:0] da, input bit do_b, input logic [7:0] db);
    @(negedge sys_clk);
    if (do_a) begin req_a = 1; data_a = da; m_pend_a = 1; m_data_a = da; end
    if (do_b) begin req_b = 1; data_b = db; m_pend_b = 1; m_data_b = db; end
    @(negedge sys_clk);
    req_a = 0; req_b = 0;
  endtask

  task automatic frame_start(input string tag, output int t0);
    int k = 0;
    while (rs485_tx_en !== 1'b1 && k < IDLE_CYC + 400) begin @(negedge sys_clk); k++; end
    check({tag, "_rise"}, rs485_tx_en, 1);
    t0 = cyc;
  endtask

  // From grant onward: lead time, strobe contents, uart_send model, tail.
  task automatic frame_finish(input string tag, input bit eb, input logic [7:0] ed,
                              input int t0, input bit make_busy);
    int k = 0, tu, tdrop;
    while (uart_en !== 1'b1 && k < LEAD_CYC + 20) begin @(negedge sys_clk); k++; end
    check({tag, "_lead"}, cyc - t0, LEAD_CYC);
    check({tag, "_din"}, uart_din, ed);
    check({tag, "_ack"}, {ack_b, ack_a}, eb ? 2'b10 : 2'b01);
    tu = cyc;
    if (!make_busy) begin
      k = 0;
      while (tx_err !== 1'b1 && k < 20) begin @(negedge sys_clk); k++; end
      check({tag, "_tmo_cyc"}, cyc - tu, 5);
      check({tag, "_tmo_txen"}, rs485_tx_en, 0);
      m_err++;
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      tx_busy = 1;
      repeat ($urandom_range(8, 40)) @(negedge sys_clk);
      tx_busy = 0;
      tdrop = cyc;
      k = 0;
      while (rs485_tx_en !== 1'b0 && k < TAIL_CYC + 20) begin @(negedge sys_clk); k++; end
      // One cycle to see tx_busy low, then the full tail window.
      check({tag, "_tail"}, cyc - tdrop, TAIL_CYC + 1);
      check({tag, "_din_hold"}, uart_din, ed);
    end
    t_fall = cyc;
  endtask

  task automatic serve(input string tag, input bit chk, input int t_ref, input bit make_busy);
    bit eb; logic [7:0] ed; int t0;
    eb = m_pick();
    ed = eb ? m_data_b : m_data_a;
    frame_start(tag, t0);
    if (chk) check_range({tag, "_gap"}, t0 - t_ref, IDLE_CYC, IDLE_CYC + 4);
    m_grant(eb);
    frame_finish(tag, eb, ed, t0, make_busy);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_req, k, hits;
    logic [7:0] cur, prev;

    // ---- reset values ----
    repeat (3) @(negedge sys_clk);
    check("rst_tx_en", rs485_tx_en, 0);
    check("rst_uart_en", uart_en, 0);
    check("rst_din", uart_din, 0);
    check("rst_ack", {ack_a, ack_b}, 0);
    check("rst_err", tx_err, 0);
    sys_rst_n = 1;

    // ---- single frame on an idle line ----
    repeat (IDLE_CYC + 20) @(negedge sys_clk);
    t_req = cyc + 1;
    request(1, 8'h05, 0, 8'h00);
    m_grant(0);
    frame_start("basic", t0);
    check_range("basic_lat", t0 - t_req, 1, 3);
    frame_finish("basic", 0, 8'h05, t0, 1);

    // ---- simultaneous requests after reset ----
    @(negedge sys_clk); sys_rst_n = 0; m_reset();
    repeat (2) @(negedge sys_clk); sys_rst_n = 1; t_fall = cyc;
    request(1, 8'h01, 1, 8'h02);
    frame_start("tie1", t0);
    check_range("tie1_gap", t0 - t_fall, IDLE_CYC, IDLE_CYC + 4);
    check("tie1_first_a", m_pick(), 0);
    m_grant(0);
    request(1, 8'($urandom), 1, 8'($urandom));   // second pair during A's frame
    frame_finish("tie1", 0, 8'h01, t0, 1);
    check("tie2_first_b", m_pick(), 1);
    serve("tie2", 1, t_fall, 1);
    serve("tie3", 1, t_fall, 1);

    // ---- latest byte wins ----
    request(1, 8'h03, 0, 8'h00);
    request(1, 8'h07, 0, 8'h00);
    serve("latest", 1, t_fall, 1);

    // ---- foreign traffic defers the grant ----
    request(0, 8'h00, 1, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      rxd = 1'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge sys_clk);
    end
    rxd = 0; @(negedge sys_clk);
    rxd = 1;
    check("busyline_no_tx", rs485_tx_en, 0);
    serve("busyline", 1, cyc, 1);

    // ---- transmit timeout, then normal service ----
    request(1, 8'($urandom), 0, 8'h00);
    serve("tmo", 1, t_fall, 0);
    request(0, 8'h00, 1, 8'($urandom));
    serve("after_tmo", 1, t_fall, 1);

    // ---- request on the very grant cycle is kept ----
    cur = 8'($urandom); prev = 8'h00;
    @(negedge sys_clk);
    req_a = 1; data_a = cur;
    k = 0;
    while (k < IDLE_CYC + 400) begin
      @(negedge sys_clk); k++;
      if (rs485_tx_en) break;
      prev = cur; cur = 8'($urandom); data_a = cur;
    end
    req_a = 0;
    check("grantreq_rise", rs485_tx_en, 1);
    t0 = cyc;
    check_range("grantreq_gap", t0 - t_fall, IDLE_CYC, IDLE_CYC + 4);
    m_pend_a = 1; m_data_a = prev;
    m_grant(0);
    m_pend_a = 1; m_data_a = cur;
    frame_finish("grantreq", 0, prev, t0, 1);
    serve("grantreq2", 1, t_fall, 1);

    // ---- reset mid-frame discards everything ----
    request(1, 8'($urandom), 0, 8'h00);
    frame_start("rstmid", t0);
    m_grant(0);
    k = 0;
    while (uart_en !== 1'b1 && k < LEAD_CYC + 20) begin @(negedge sys_clk); k++; end
    tx_busy = 1;
    request(0, 8'h00, 1, 8'($urandom));
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 0;
    #1;
    check("rstmid_txen", rs485_tx_en, 0);
    check("rstmid_din", uart_din, 0);
    tx_busy = 0; m_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1;
    hits = 0;
    repeat (IDLE_CYC + 50) begin
      @(negedge sys_clk);
      if (rs485_tx_en !== 1'b0 || uart_en !== 1'b0) hits++;
    end
    check("rstmid_discard", hits, 0);

    // ---- pulse totals ----
    @(negedge sys_clk);
    check("tot_ack_a", cnt_ack_a, m_ack_a);
    check("tot_ack_b", cnt_ack_b, m_ack_b);
    check("tot_uart_en", cnt_uen, m_ack_a + m_ack_b);
    check("tot_err", cnt_err, m_err);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
